seq_det_match_monitor: RTL
==========================

// Module: seq_det_match_monitor
// PURPOSE
//  Downstream consumer of the 1010 Mealy sequence detector's one-cycle match output.
//  On Start, opens a fixed window of WIN_LEN clock cycles and counts the match pulses seen in it.
//  At window end it reports Count and a threshold Alarm, then returns to idle.
//  Feeds status/alarm logic that rates link-pattern quality.
// PARAMETERS
//  WIN_LEN  16  window length in Clk cycles (>=2)
//  CNT_W    8   width of match counter
//  THRESH   3   Alarm asserted when final Count >= THRESH (THRESH < 2**CNT_W)
//  localparam WIN_W = $clog2(WIN_LEN) (min 1): width of window down-counter
// PORTS
//  Clk    in   1      clock, rising edge
//  Rst    in   1      reset, asynchronous, active-low
//  Det    in   1      match pulse from detector (OP), sampled every Clk
//  Start  in   1      open a window; honoured only in IDLE
//  Clr    in   1      synchronous abort/clear, highest priority
//  Busy   out  1      1 while in RUN
//  Done   out  1      one-cycle pulse in REPORT
//  Count  out  CNT_W  matches counted in current/last window
//  Alarm  out  1      registered threshold result, held until next Start or Clr
//  State  out  2      current FSM state (debug)
// BEHAVIOUR
//  Reset (Rst=0): State=IDLE, Busy=0, Done=0, Count=0, Alarm=0, window counter=0.
//  Encoding: IDLE=0, RUN=1, REPORT=2; 3 is illegal -> IDLE next cycle.
//  IDLE:   Start=1 -> RUN; Count<=0, Alarm<=0, WinCnt<=WIN_LEN-1. Det is ignored in IDLE.
//  RUN:    Busy=1. Each cycle with Det=1: Count<=Count+1, saturating at all-ones (no wrap).
//          WinCnt decrements each cycle. On the cycle with WinCnt==0 (Det still counted) -> REPORT.
//          The window is exactly WIN_LEN RUN cycles. Start is ignored.
//  REPORT: Done=1 for exactly one cycle; Alarm<=(Count>=THRESH) at the REPORT->IDLE edge.
//          Count is held. Det and Start are ignored. Next state is IDLE.
//  Latency: Start sampled at edge k -> Busy high for cycles k+1..k+WIN_LEN.
//           Done high in cycle k+WIN_LEN+1. Alarm valid from k+WIN_LEN+2.
//  Back-to-back: Start may be reasserted in the first IDLE cycle after REPORT.
//           Count/Alarm then clear on that Start edge.
//  Clr=1 (any state): next State=IDLE, Count<=0, Alarm<=0, Done=0, WinCnt<=0.
//           Clr wins over a simultaneous Start, Det or window end.
//  Rst asserted mid-window: immediate asynchronous return to reset values; no Done pulse.
//  Busy and Done are decoded from the State register (glitch-free, no In-path).
// CONFIGURATION
//  MATCH_MON_OVF_EN defined: extra port Ovf (out, 1) = sticky flag.
//    Ovf set when Det=1 in RUN while Count is all-ones. Cleared by Start (from IDLE), Clr and Rst.
//    Reset value 0.
//  Not defined: Ovf port and logic absent. Count still saturates silently.
// TESTING
//  1 Rst low with Det/Start toggling -> all outputs 0, State=0. Rst release -> stays IDLE.
//  2 WIN_LEN=16, Start@c0, Det pulses @c3,c7,c16 -> Busy c1..c16, Done@c17, Count=3, Alarm=1 @c18.
//    The c16 pulse (last window cycle) is counted.
//  3 Det pulses only in IDLE and REPORT, none in RUN -> Count=0, Alarm=0, Done pulses once.
//  4 Clr@c5 during RUN with Start also high @c5 -> IDLE @c6, Count=0, no Done.
//    Start@c7 -> fresh window.
//  5 CNT_W=2, Det=1 every RUN cycle -> Count sticks at 3.
//    With MATCH_MON_OVF_EN: Ovf=1 from 4th pulse; cleared by next Start.
//  6 Start held high continuously -> windows repeat every WIN_LEN+2 cycles.
//    One Done per window; Start during RUN has no effect.

Source files
------------

// File: rtl/seq_det_match_monitor_if.sv
// seq_det_match_monitor_if: handshake/status bundle between a 1010-match producer and the match monitor
// Signals: Det/Start/Clr (master -> slave), Busy/Done/Count/Alarm/State (slave -> master).
// With MATCH_MON_OVF_EN defined the bundle also carries the sticky Ovf flag (slave -> master).
interface seq_det_match_monitor_if #(
    parameter int CNT_W = 8
);
    logic             Det;
    logic             Start;
    logic             Clr;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Count;
    logic             Alarm;
    logic [1:0]       State;
`ifdef MATCH_MON_OVF_EN
    logic             Ovf;
    modport master (input Ovf, output Det, Start, Clr, input Busy, Done, Count, Alarm, State);
    modport slave  (output Ovf, input Det, Start, Clr, output Busy, Done, Count, Alarm, State);
`else
    modport master (output Det, Start, Clr, input Busy, Done, Count, Alarm, State);
    modport slave  (input Det, Start, Clr, output Busy, Done, Count, Alarm, State);
`endif
endinterface

// File: rtl/seq_det_match_monitor.sv
// seq_det_match_monitor: counts detector match pulses over a WIN_LEN-cycle window and reports Count plus a threshold Alarm
// Ports: Clk (rising edge), Rst (asynchronous, active-low), bus (slave modport):
//   in  Det, Start, Clr; out Busy, Done, Count[CNT_W], Alarm, State[2] (IDLE=0, RUN=1, REPORT=2).
// Optional MATCH_MON_OVF_EN adds the sticky Ovf output (Det seen in RUN while Count is saturated).
module seq_det_match_monitor #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int THRESH  = 3
) (
    input logic                  Clk,
    input logic                  Rst,
    seq_det_match_monitor_if.slave bus
);
    localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REPORT = 2'd2} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             alarm_q, alarm_d;
    logic             cnt_full;
    assign cnt_full = &count_q;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        win_d   = win_q;
        alarm_d = alarm_q;
        if (bus.Clr) begin
            state_d = IDLE;
            count_d = '0;
            win_d   = '0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.Start) begin
                    state_d = RUN;
                    count_d = '0;
                    win_d   = WIN_W'(WIN_LEN - 1);
                    alarm_d = 1'b0;
                end
                RUN: begin
                    // the final window cycle still counts its Det pulse
                    count_d = (bus.Det && !cnt_full) ? count_q + 1'b1 : count_q;
                    win_d   = (win_q == '0) ? '0 : win_q - 1'b1;
                    state_d = (win_q == '0) ? REPORT : RUN;
                end
                REPORT: begin
                    alarm_d = (count_q >= CNT_W'(THRESH));
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            count_q <= '0;
            win_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            win_q   <= win_d;
            alarm_q <= alarm_d;
        end
    end
    // status outputs decode straight from registers so they cannot glitch on input changes
    assign bus.State = state_q;
    assign bus.Busy  = (state_q == RUN);
    assign bus.Done  = (state_q == REPORT);
    assign bus.Count = count_q;
    assign bus.Alarm = alarm_q;
`ifdef MATCH_MON_OVF_EN
    logic ovf_q;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            ovf_q <= 1'b0;
        else if (bus.Clr || (state_q == IDLE && bus.Start))
            ovf_q <= 1'b0;
        else if (state_q == RUN && bus.Det && cnt_full)
            ovf_q <= 1'b1;
    end
    assign bus.Ovf = ovf_q;
`endif
endmodule
